// File: rtl/dsm_pkg.sv
// Shared types and defaults for the delta-sigma bit-line sense controller.
// Also holds helpers to read and write one channel's slice of the packed result.
package dsm_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, DONE} dsm_state_e;

  localparam int DSM_NCH        = 4;
  localparam int DSM_CNT_W      = 9;
  localparam int DSM_SETTLE_CYC = 2;

  localparam int DSM_RES_W = DSM_NCH * DSM_CNT_W;

  function automatic logic [DSM_CNT_W-1:0] res_get(input logic [DSM_RES_W-1:0] r,
                                                   input int i);
    return r[i*DSM_CNT_W +: DSM_CNT_W];
  endfunction

  function automatic logic [DSM_RES_W-1:0] res_put(input logic [DSM_RES_W-1:0] r,
                                                   input int i,
                                                   input logic [DSM_CNT_W-1:0] v);
    logic [DSM_RES_W-1:0] t;
    t = r;
    t[i*DSM_CNT_W +: DSM_CNT_W] = v;
    return t;
  endfunction

endpackage

// File: rtl/dsm_chan_cnt.sv
// One channel of the sense array: registered injection request and injection counter.
// A comparator value that is not a clean 0 is treated as "above vref" (no injection).
module dsm_chan_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sample,
  input  logic             comp,
  output logic             inj,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inj   <= 1'b0;
      count <= '0;
    end else if (sample) begin
      if (comp == 1'b0) begin
        inj   <= 1'b1;
        count <= count + 1'b1;
      end else begin
        inj   <= 1'b0;
      end
    end else begin
      inj <= 1'b0;
    end
  end

endmodule

// File: rtl/dsm_sense_ctrl.sv
// Delta-sigma bit-line sense controller: FSM, settle/window timers and result register.
// Per-channel counting lives in dsm_chan_cnt instances.
module dsm_sense_ctrl
  import dsm_pkg::*;
#(
  parameter int NCH        = DSM_NCH,
  parameter int CNT_W      = DSM_CNT_W,
  parameter int SETTLE_CYC = DSM_SETTLE_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 supply_ok,
  input  logic                 mode_cont,
  input  logic                 start,
  input  logic [CNT_W-1:0]     win_len,
  input  logic [NCH-1:0]       comp,
  output logic [NCH-1:0]       inj,
  output logic                 busy,
  output logic [NCH*CNT_W-1:0] result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 abort
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

  dsm_state_e           state;
  logic [CNT_W-1:0]     win_q;
  logic [CNT_W-1:0]     win_cnt;
  logic [SET_W-1:0]     set_cnt;
  logic                 mode_q;
  logic                 fault;
  logic                 start_acc;
  logic                 sample;
  logic                 last_smp;
  logic                 clr;
  logic [CNT_W-1:0]     cnt [NCH];
  logic [NCH*CNT_W-1:0] res_nxt;

  assign fault     = ~en | ~supply_ok;
  assign start_acc = (state == IDLE) & start & en & supply_ok & (win_len != '0);
  assign sample    = (state == CONVERT) & ~fault;
  assign last_smp  = sample & (win_cnt == '0);
  // Counters clear on settle entry, on window completion (so a continuous restart
  // begins at zero) and on abort.
  assign clr       = start_acc | last_smp | ((state != IDLE) & fault);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dsm_chan_cnt #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .sample (sample),
      .comp   (comp[g]),
      .inj    (inj[g]),
      .count  (cnt[g])
    );
  end

  // The final window sample still counts, so the result is the count plus this edge's decision.
  always_comb begin
    res_nxt = '0;
    for (int i = 0; i < NCH; i++) begin
      res_nxt[i*CNT_W +: CNT_W] = cnt[i];
      if (comp[i] == 1'b0) res_nxt[i*CNT_W +: CNT_W] = cnt[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      abort        <= 1'b0;
      win_q        <= '0;
      win_cnt      <= '0;
      set_cnt      <= '0;
      mode_q       <= 1'b0;
    end else begin
      abort <= 1'b0;
      if ((state != IDLE) && fault) begin
        state        <= IDLE;
        busy         <= 1'b0;
        result_valid <= 1'b0;
        abort        <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_acc) begin
              state   <= SETTLE;
              busy    <= 1'b1;
              win_q   <= win_len;
              mode_q  <= mode_cont;
              set_cnt <= SET_LOAD;
            end
          end
          SETTLE: begin
            if (set_cnt == '0) begin
              state   <= CONVERT;
              win_cnt <= win_q - 1'b1;
            end else begin
              set_cnt <= set_cnt - 1'b1;
            end
          end
          CONVERT: begin
            if (last_smp) begin
              state        <= DONE;
              result       <= res_nxt;
              result_valid <= 1'b1;
            end else begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
          DONE: begin
            if (result_ready) begin
              result_valid <= 1'b0;
              if (mode_q) begin
                state   <= CONVERT;
                win_cnt <= win_q - 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsm_sense_ctrl.sv
// Bench for dsm_sense_ctrl: table of constant-pattern conversions, randomized windows
// against a per-window counting model, and hand-written abort/reset/continuous sequences.
module tb_dsm_sense_ctrl;
  import dsm_pkg::*;

  localparam int NCH        = 4;
  localparam int CNT_W      = 9;
  localparam int SETTLE_CYC = 2;
  localparam int RW         = NCH * CNT_W;

  logic             clk = 1'b0;
  logic             rst, en, supply_ok, mode_cont, start, result_ready;
  logic [CNT_W-1:0] win_len;
  logic [NCH-1:0]   comp, inj;
  logic             busy, result_valid, abort;
  logic [RW-1:0]    result;

  int            n_checks = 0;
  int            n_err    = 0;
  logic [RW-1:0] last_res;

  typedef struct {
    int             win;
    logic [NCH-1:0] cpat;
    int             kind;
    logic           poke;
    logic [RW-1:0]  exp;
  } vec_t;

  vec_t tbl [7];

  dsm_sense_ctrl #(.NCH(NCH), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .supply_ok    (supply_ok),
    .mode_cont    (mode_cont),
    .start        (start),
    .win_len      (win_len),
    .comp         (comp),
    .inj          (inj),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] mk(input int c3, input int c2, input int c1, input int c0);
    logic [RW-1:0] r;
    r = '0;
    r = res_put(r, 0, CNT_W'(c0));
    r = res_put(r, 1, CNT_W'(c1));
    r = res_put(r, 2, CNT_W'(c2));
    r = res_put(r, 3, CNT_W'(c3));
    return r;
  endfunction

  // Drives one window and models it: every comparator 0 seen on a sample edge adds one
  // to that channel; inj follows the inverted sample except after the final sample.
  // Step s is the s-th posedge of the call; samples occupy steps first .. first+win-1.
  // kind: 0 constant cpat, 1 random, 2 cpat with ch0 toggling 0,1,0,... per sample.
  task automatic run_window(input int win, input int first, input int kind,
                            input logic [NCH-1:0] cpat, input logic poke,
                            output logic [RW-1:0] mres);
    int             cnt [NCH];
    int             last;
    logic           smp;
    logic [NCH-1:0] c, e;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    last = first + win - 1;
    for (int s = 1; s <= last; s++) begin
      smp = (s >= first);
      case (kind)
        1:       c = NCH'($urandom());
        2: begin
          c    = cpat;
          c[0] = (((s - first) % 2) == 1);
        end
        default: c = cpat;
      endcase
      comp = c;
      if (poke && s == 4) begin
        start   = 1'b1;
        win_len = CNT_W'(20);
      end
      tick();
      start        = 1'b0;
      result_ready = 1'b0;
      if (smp) for (int i = 0; i < NCH; i++) if (c[i] == 1'b0) cnt[i]++;
      e = (smp && s != last) ? ~c : '0;
      chk("win_inj", inj, e);
      chk("win_busy", busy, 1);
      chk("win_abort", abort, 0);
      chk("win_valid", result_valid, (s == last) ? 1 : 0);
    end
    mres = '0;
    for (int i = 0; i < NCH; i++) mres = res_put(mres, i, CNT_W'(cnt[i]));
    chk("win_result", result, mres);
  endtask

  task automatic single(input int win, input int kind, input logic [NCH-1:0] cpat,
                        input logic poke, output logic [RW-1:0] mres);
    win_len   = CNT_W'(win);
    mode_cont = 1'b0;
    start     = 1'b1;
    run_window(win, SETTLE_CYC + 2, kind, cpat, poke, mres);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("hs_valid", result_valid, 0);
    chk("hs_busy", busy, 0);
    last_res = mres;
  endtask

  initial begin
    logic [RW-1:0] m, m1, m2;

    tbl[0] = '{win: 10,  cpat: 4'b0101, kind: 0, poke: 1'b0, exp: mk(10, 0, 10, 0)};
    tbl[1] = '{win: 1,   cpat: 4'b0000, kind: 0, poke: 1'b0, exp: mk(1, 1, 1, 1)};
    tbl[2] = '{win: 511, cpat: 4'b1110, kind: 0, poke: 1'b0, exp: mk(0, 0, 0, 511)};
    tbl[3] = '{win: 7,   cpat: 4'b1111, kind: 0, poke: 1'b0, exp: mk(0, 0, 0, 0)};
    tbl[4] = '{win: 8,   cpat: 4'b1100, kind: 2, poke: 1'b0, exp: mk(0, 0, 8, 4)};
    tbl[5] = '{win: 3,   cpat: 4'b0011, kind: 0, poke: 1'b0, exp: mk(3, 3, 0, 0)};
    tbl[6] = '{win: 6,   cpat: 4'b0110, kind: 0, poke: 1'b1, exp: mk(6, 0, 0, 6)};

    rst = 1'b1; en = 1'b1; supply_ok = 1'b1; mode_cont = 1'b0; start = 1'b0;
    result_ready = 1'b0; win_len = '0; comp = '1; last_res = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_inj", inj, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_abort", abort, 0);

    // start with a zero window is ignored
    win_len = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_busy", busy, 0);
    chk("zero_abort", abort, 0);
    tick();
    chk("zero_busy2", busy, 0);

    for (int k = 0; k < 7; k++) begin
      single(tbl[k].win, tbl[k].kind, tbl[k].cpat, tbl[k].poke, m);
      chk("tbl_model", m, tbl[k].exp);
      chk("tbl_result", result, tbl[k].exp);
    end

    for (int k = 0; k < 6; k++) begin
      single(int'($urandom_range(1, 40)), 1, '0, 1'b0, m);
    end

    // supply fault on the third CONVERT edge
    win_len = CNT_W'(10); mode_cont = 1'b0; comp = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 2; s <= SETTLE_CYC + 3; s++) tick();
    chk("pre_flt_inj", inj, 4'b1010);
    supply_ok = 1'b0;
    tick();
    supply_ok = 1'b1;
    chk("flt_abort", abort, 1);
    chk("flt_inj", inj, 0);
    chk("flt_valid", result_valid, 0);
    chk("flt_busy", busy, 0);
    chk("flt_result_kept", result, last_res);
    tick();
    chk("flt_abort_1cyc", abort, 0);
    single(5, 0, 4'b1001, 1'b0, m);
    chk("post_flt_result", result, mk(0, 5, 5, 0));

    // continuous mode: stall in DONE, then restart without settle
    win_len = CNT_W'(4); mode_cont = 1'b1; start = 1'b1;
    run_window(4, SETTLE_CYC + 2, 1, '0, 1'b0, m1);
    mode_cont = 1'b0;
    for (int k = 0; k < 5; k++) begin
      comp = NCH'($urandom());
      tick();
      chk("stall_result", result, m1);
      chk("stall_valid", result_valid, 1);
      chk("stall_inj", inj, 0);
      chk("stall_busy", busy, 1);
    end
    result_ready = 1'b1;
    run_window(4, 2, 1, '0, 1'b0, m2);
    tick();
    chk("cont_hold", result, m2);
    en = 1'b0;
    tick();
    en = 1'b1;
    chk("cont_abort", abort, 1);
    chk("cont_valid", result_valid, 0);
    chk("cont_busy", busy, 0);
    chk("cont_result_kept", result, m2);
    tick();
    chk("cont_abort_1cyc", abort, 0);

    // reset in the middle of a conversion
    win_len = CNT_W'(20); mode_cont = 1'b0; comp = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_inj", inj, 4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_inj", inj, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_result", result, 0);
    chk("mrst_valid", result_valid, 0);
    chk("mrst_abort", abort, 0);
    tick();
    chk("mrst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
